// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI write-channel widths, codes and FSM state type
// Purpose : common definitions for the AXI write slave port.
// Contents: channel field widths, burst/size/response codes, write FSM states.
package axi_pkg;

   localparam int AXI_ID_W    = 8;
   localparam int AXI_ADDR_W  = 32;
   localparam int AXI_DATA_W  = 32;
   localparam int AXI_STRB_W  = 4;
   localparam int AXI_LEN_W   = 4;
   localparam int AXI_SIZE_W  = 3;
   localparam int AXI_BURST_W = 2;
   localparam int AXI_RESP_W  = 2;

   localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'b01;
   localparam logic [AXI_SIZE_W-1:0]  SIZE_4BYTE  = 3'b010;
   localparam logic [AXI_RESP_W-1:0]  RESP_OKAY   = 2'b00;
   localparam logic [AXI_RESP_W-1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_RESP = 2'd2
   } wr_state_e;

endpackage

// File: rtl/slave_write_port.sv
// rtl/slave_write_port.sv - single-outstanding AXI write slave driving a word memory port
// Purpose : accepts one INCR write burst at a time, forwards each beat to a
//           simple memory write port with zero latency, then returns a B response.
// Ports   : ACLK/ARESETn      clock, async active-low reset
//           AW* / W* / B*     AXI write address, data and response channels
//           mem_cs/mem_we     memory strobe and byte write enables
//           mem_addr/mem_din  memory word address and write data
module slave_write_port
   import axi_pkg::*;
#(
   parameter logic [31:0] ADDR_LO = 32'h0000_0000,
   parameter logic [31:0] ADDR_HI = 32'h0000_FFFF
) (
   input  logic                   ACLK,
   input  logic                   ARESETn,
   input  logic [AXI_ID_W-1:0]    AWID,
   input  logic [AXI_ADDR_W-1:0]  AWADDR,
   input  logic [AXI_LEN_W-1:0]   AWLEN,
   input  logic [AXI_SIZE_W-1:0]  AWSIZE,
   input  logic [AXI_BURST_W-1:0] AWBURST,
   input  logic                   AWVALID,
   output logic                   AWREADY,
   input  logic [AXI_DATA_W-1:0]  WDATA,
   input  logic [AXI_STRB_W-1:0]  WSTRB,
   input  logic                   WLAST,
   input  logic                   WVALID,
   output logic                   WREADY,
   output logic [AXI_ID_W-1:0]    BID,
   output logic [AXI_RESP_W-1:0]  BRESP,
   output logic                   BVALID,
   input  logic                   BREADY,
   output logic                   mem_cs,
   output logic [AXI_STRB_W-1:0]  mem_we,
   output logic [29:0]            mem_addr,
   output logic [AXI_DATA_W-1:0]  mem_din
);

   wr_state_e             state_q, state_d;
   logic [AXI_ID_W-1:0]   id_q, id_d;
   logic [29:0]           waddr_q, waddr_d;   // word part of the burst start address
   logic [AXI_LEN_W-1:0]  len_q, len_d;
   logic [AXI_LEN_W-1:0]  cnt_q, cnt_d;
   logic                  err_q, err_d;       // address/attribute error, writes suppressed
   logic                  perr_q, perr_d;     // WLAST placement error

   logic [32:0]           aw_last_addr;
   logic                  aw_err;
   logic                  last_cnt;

   // The burst is linear, so checking the first and last beat addresses covers
   // every beat. Signed compares on zero-extended values keep the check valid
   // for any parameter values, including ADDR_LO == 0.
   always_comb begin
      aw_last_addr = {1'b0, AWADDR} + {27'b0, AWLEN, 2'b00};
      aw_err = (AWBURST != BURST_INCR)
            || (AWSIZE != SIZE_4BYTE)
            || (AWADDR[1:0] != 2'b00)
            || ($signed({1'b0, AWADDR}) < $signed({1'b0, ADDR_LO}))
            || ($signed({1'b0, aw_last_addr}) > $signed({2'b00, ADDR_HI}));
   end

   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      waddr_d  = waddr_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      perr_d   = perr_q;
      last_cnt = (cnt_q == len_q);
      AWREADY  = 1'b0;
      WREADY   = 1'b0;
      BVALID   = 1'b0;
      BID      = '0;
      BRESP    = RESP_OKAY;
      mem_cs   = 1'b0;
      mem_we   = '0;
      mem_addr = '0;
      mem_din  = '0;

      case (state_q)
         ST_IDLE: begin
            // Gated so the port reads as not-ready while reset is held.
            AWREADY = ARESETn;
            if (AWVALID && ARESETn) begin
               id_d    = AWID;
               waddr_d = AWADDR[31:2];
               len_d   = AWLEN;
               err_d   = aw_err;
               cnt_d   = '0;
               perr_d  = 1'b0;
               state_d = ST_DATA;
            end
         end

         ST_DATA: begin
            WREADY = 1'b1;
            if (WVALID) begin
               if (!err_q) begin
                  mem_cs   = 1'b1;
                  mem_we   = WSTRB;
                  mem_addr = waddr_q + {26'b0, cnt_q};
                  mem_din  = WDATA;
               end
               // WLAST must coincide exactly with the final counted beat.
               if (WLAST != last_cnt) begin
                  perr_d = 1'b1;
               end
               cnt_d = cnt_q + 4'd1;
               if (WLAST || last_cnt) begin
                  state_d = ST_RESP;
               end
            end
         end

         ST_RESP: begin
            BVALID = 1'b1;
            BID    = id_q;
            BRESP  = (err_q || perr_q) ? RESP_SLVERR : RESP_OKAY;
            if (BREADY) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= ST_IDLE;
         id_q    <= '0;
         waddr_q <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         waddr_q <= waddr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         perr_q  <= perr_d;
      end
   end

endmodule

// File: tb/tb_slave_write_port.sv
// tb/tb_slave_write_port.sv - self-checking bench for slave_write_port
module tb_slave_write_port;

   localparam logic [31:0] LO = 32'h0000_0000;
   localparam logic [31:0] HI = 32'h0000_FFFF;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic [7:0]  AWID;
   logic [31:0] AWADDR;
   logic [3:0]  AWLEN;
   logic [2:0]  AWSIZE;
   logic [1:0]  AWBURST;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WLAST;
   logic        WVALID;
   logic        WREADY;
   logic [7:0]  BID;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic        mem_cs;
   logic [3:0]  mem_we;
   logic [29:0] mem_addr;
   logic [31:0] mem_din;

   slave_write_port #(.ADDR_LO(LO), .ADDR_HI(HI)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
      .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din)
   );

   always #5 ACLK = ~ACLK;

   typedef struct packed {
      logic [29:0] a;
      logic [3:0]  we;
      logic [31:0] d;
   } wr_t;

   wr_t         exp_q[$];
   logic [29:0] log_addr[$];
   logic [3:0]  log_we[$];
   logic [31:0] log_din[$];
   int          pass_cnt = 0;
   int          total_cnt = 0;
   bit          cur_err;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      total_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, req);
   endtask

   // Address/attribute error rule evaluated on whole-number byte addresses.
   function automatic bit model_err(input logic [31:0] a, input logic [3:0] l,
                                    input logic [2:0] s, input logic [1:0] b);
      longint first, last;
      first = a;
      last  = first + 4 * longint'(l);
      return (b != 2'b01) || (s != 3'b010) || (a % 4 != 0)
          || (first < longint'(LO)) || (last > longint'(HI));
   endfunction

   // Memory port and reset-state checker, every cycle.
   always @(negedge ACLK) begin
      if (!ARESETn) begin
         chk({AWREADY, WREADY, BVALID, BID, BRESP, mem_cs, mem_we} == 18'd0
             && mem_addr == 30'd0 && mem_din == 32'd0, "reset_outputs",
             {AWREADY, WREADY, BVALID, BID, BRESP, mem_cs, mem_we}, 0);
      end else if (mem_cs) begin
         if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_write", {mem_addr, mem_we}, 0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk({mem_addr, mem_we, mem_din} == e && WVALID && WREADY, "mem_write",
                {mem_addr, mem_we, mem_din}, e);
         end
         log_addr.push_back(mem_addr);
         log_we.push_back(mem_we);
         log_din.push_back(mem_din);
      end else begin
         chk(mem_we == 4'd0 && mem_addr == 30'd0 && mem_din == 32'd0, "mem_bus_quiet",
             {mem_we, mem_addr}, 0);
      end
   end

   task automatic aw(input logic [7:0] id, input logic [31:0] a, input logic [3:0] l,
                     input logic [2:0] s, input logic [1:0] b);
      cur_err = model_err(a, l, s, b);
      AWID = id; AWADDR = a; AWLEN = l; AWSIZE = s; AWBURST = b; AWVALID = 1'b1;
      for (int t = 0; t < 20; t++) begin
         @(negedge ACLK);
         if (AWREADY) break;
      end
      chk(AWREADY, "awready_timeout", AWREADY, 1);
      chk(!WREADY && !BVALID, "idle_w_b_low", {WREADY, BVALID}, 0);
      @(posedge ACLK);
      #1;
      AWVALID = 1'b0;
   endtask

   task automatic beat(input logic [31:0] d, input logic [3:0] strb, input bit last,
                       input bit wr, input logic [29:0] wa);
      if (wr) exp_q.push_back({wa, strb, d});
      WDATA = d; WSTRB = strb; WLAST = last; WVALID = 1'b1;
      for (int t = 0; t < 20; t++) begin
         @(negedge ACLK);
         if (WREADY) break;
      end
      chk(WREADY, "wready_timeout", WREADY, 1);
      if (!WREADY) exp_q.delete();
      @(posedge ACLK);
      #1;
      WVALID = 1'b0; WLAST = 1'b0; WDATA = '0; WSTRB = '0;
   endtask

   task automatic resp(input logic [7:0] id, input logic [1:0] br, input int hold);
      logic [7:0] b0;
      logic [1:0] r0;
      BREADY = (hold == 0);
      @(negedge ACLK);
      chk(BVALID, "bvalid_after_last_beat", BVALID, 1);
      chk(BID == id, "bid", BID, id);
      chk(BRESP == br, "bresp", BRESP, br);
      chk(!WREADY && !AWREADY, "resp_ready_low", {WREADY, AWREADY}, 0);
      b0 = BID;
      r0 = BRESP;
      for (int k = 1; k <= hold; k++) begin
         @(posedge ACLK);
         #1;
         if (k == hold) BREADY = 1'b1;
         @(negedge ACLK);
         chk(BVALID && BID == b0 && BRESP == r0, "b_stable", {BVALID, BID, BRESP}, {1'b1, b0, r0});
      end
      @(posedge ACLK);
      #1;
      BREADY = 1'b0;
      @(negedge ACLK);
      chk(!BVALID && AWREADY, "back_to_idle", {BVALID, AWREADY}, 2'b01);
      @(posedge ACLK);
      #1;
   endtask

   // Model of one burst: beats accepted up to the first WLAST or the AWLEN-th beat,
   // writes only when the address phase was clean, SLVERR on any error.
   task automatic run_burst(input logic [7:0] id, input logic [31:0] a, input logic [3:0] l,
                            input logic [2:0] s, input logic [1:0] b, input int last_at,
                            input logic [3:0] strb, input logic [31:0] dbase, input int hold);
      int n;
      logic [1:0] br;
      aw(id, a, l, s, b);
      n = ((last_at < int'(l)) ? last_at : int'(l)) + 1;
      for (int i = 0; i < n; i++) begin
         logic [31:0] ba;
         ba = a + 32'(4 * i);
         beat(dbase + 32'(i), strb, i == last_at, !cur_err, ba[31:2]);
      end
      br = (cur_err || last_at != int'(l)) ? 2'b10 : 2'b00;
      resp(id, br, hold);
   endtask

   task automatic stray_w();
      WVALID = 1'b1; WLAST = 1'b1; WDATA = 32'hFFFF_FFFF; WSTRB = 4'hF;
      repeat (2) begin
         @(negedge ACLK);
         chk(!WREADY, "stray_w_ignored", WREADY, 0);
         @(posedge ACLK);
         #1;
      end
      WVALID = 1'b0; WLAST = 1'b0; WDATA = '0; WSTRB = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int n0;
      ARESETn = 1'b0;
      AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
      WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
      repeat (3) @(posedge ACLK);
      #1;
      ARESETn = 1'b1;
      @(negedge ACLK);
      chk(AWREADY && !WREADY && !BVALID, "reset_release", {AWREADY, WREADY, BVALID}, 3'b100);
      @(posedge ACLK);
      #1;

      // 4-beat burst at 0x100
      log_addr.delete(); log_we.delete(); log_din.delete();
      run_burst(8'h11, 32'h100, 4'd3, 3'b010, 2'b01, 3, 4'hF, 32'hA0, 1);
      chk(cur_err == 1'b0, "model_pin_clean", cur_err, 0);
      chk(log_addr.size() == 4, "burst4_count", log_addr.size(), 4);
      if (log_addr.size() == 4) begin
         chk(log_addr[0] == 30'h40 && log_addr[3] == 30'h43, "burst4_addr",
             {log_addr[0], log_addr[3]}, {30'h40, 30'h43});
         chk(log_din[0] == 32'hA0 && log_din[3] == 32'hA3 && log_we[2] == 4'hF, "burst4_data",
             log_din[3], 32'hA3);
      end

      // single beat, partial strobe, B held off 5 cycles
      n0 = log_addr.size();
      run_burst(8'h22, 32'h200, 4'd0, 3'b010, 2'b01, 0, 4'b0011, 32'hDEAD_BEEF, 5);
      chk(log_addr.size() == n0 + 1, "single_count", log_addr.size(), n0 + 1);
      if (log_addr.size() == n0 + 1)
         chk(log_we[n0] == 4'b0011 && log_din[n0] == 32'hDEAD_BEEF && log_addr[n0] == 30'h80,
             "single_write", {log_we[n0], log_din[n0]}, {4'b0011, 32'hDEAD_BEEF});

      // out-of-range start address
      n0 = log_addr.size();
      run_burst(8'h33, 32'h1_0000, 4'd1, 3'b010, 2'b01, 1, 4'hF, 32'h10, 0);
      chk(cur_err == 1'b1, "model_pin_range", cur_err, 1);
      chk(log_addr.size() == n0, "range_no_write", log_addr.size(), n0);

      // early WLAST, then stray W traffic
      n0 = log_addr.size();
      run_burst(8'h44, 32'h300, 4'd3, 3'b010, 2'b01, 1, 4'hF, 32'h50, 0);
      chk(log_addr.size() == n0 + 2, "early_wlast_writes", log_addr.size(), n0 + 2);
      stray_w();

      // bad burst type, bad size, misaligned
      n0 = log_addr.size();
      run_burst(8'h55, 32'h400, 4'd1, 3'b010, 2'b10, 1, 4'hF, 32'h60, 0);
      run_burst(8'h56, 32'h400, 4'd1, 3'b001, 2'b01, 1, 4'hF, 32'h61, 0);
      run_burst(8'h57, 32'h402, 4'd0, 3'b010, 2'b01, 0, 4'hF, 32'h62, 0);
      chk(log_addr.size() == n0, "attr_err_no_write", log_addr.size(), n0);

      // upper boundary: last beat exactly at 0xFFFC, then one word past it
      run_burst(8'h58, 32'hFFF0, 4'd3, 3'b010, 2'b01, 3, 4'h5, 32'h70, 0);
      run_burst(8'h59, 32'hFFF4, 4'd3, 3'b010, 2'b01, 3, 4'h5, 32'h80, 2);

      // WLAST missing on final beat
      run_burst(8'h5A, 32'h800, 4'd1, 3'b010, 2'b01, 9, 4'hC, 32'h90, 0);

      // reset mid-burst
      aw(8'h66, 32'h500, 4'd3, 3'b010, 2'b01);
      beat(32'hB0, 4'hF, 1'b0, 1'b1, 30'h140);
      beat(32'hB1, 4'hF, 1'b0, 1'b1, 30'h141);
      ARESETn = 1'b0;
      @(negedge ACLK);
      chk(!BVALID && !WREADY && !mem_cs, "reset_mid_burst", {BVALID, WREADY, mem_cs}, 0);
      @(posedge ACLK);
      #1;
      ARESETn = 1'b1;
      @(negedge ACLK);
      chk(AWREADY && !BVALID, "post_reset_awready", {AWREADY, BVALID}, 2'b10);
      @(posedge ACLK);
      #1;
      run_burst(8'h77, 32'h600, 4'd1, 3'b010, 2'b01, 1, 4'hF, 32'hC0, 0);

      chk(exp_q.size() == 0, "all_writes_seen", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/slave_write_port.md
SLAVE_WRITE_PORT -- requirements
Module: slave_write_port

Interface
REQ-001 SHALL have parameter ADDR_LO, default 32'h0000_0000, lowest accepted byte address.
REQ-002 SHALL have parameter ADDR_HI, default 32'h0000_FFFF, highest accepted byte address.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: ACLK input 1 (clock); ARESETn input 1 (reset).
REQ-004 AWID input 8, write address ID; AWADDR input 32, byte start address; AWLEN input 4, beats minus one; AWSIZE input 3, must be 3'b010; AWBURST input 2, must be INCR (2'b01).
REQ-005 AWVALID input 1, address valid; AWREADY output 1, address accepted.
REQ-006 WDATA input 32; WSTRB input 4, byte lanes; WLAST input 1, final beat; WVALID input 1; WREADY output 1.
REQ-007 BID output 8, response ID; BRESP output 2, response code; BVALID output 1; BREADY input 1.
REQ-008 mem_cs output 1, memory access strobe; mem_we output 4, active-high byte write enables; mem_addr output 30, word address; mem_din output 32, write data.

Function
REQ-009 SHALL implement FSM states IDLE, DATA, RESP; one outstanding transaction only.
REQ-010 IDLE: AWREADY=1, WREADY=0, BVALID=0; on AWVALID&AWREADY latch AWID, AWADDR, AWLEN, err flag; go to DATA next cycle.
REQ-011 Err flag set at AW handshake if AWBURST!=2'b01, AWSIZE!=3'b010, AWADDR[1:0]!=0, or any beat address (AWADDR+4*AWLEN) outside [ADDR_LO, ADDR_HI].
REQ-012 DATA: AWREADY=0, WREADY=1; each WVALID&WREADY is one beat.
REQ-013 Per beat with err flag clear: mem_cs=1, mem_we=WSTRB, mem_addr=current byte address [31:2], mem_din=WDATA, same cycle (combinational, zero latency).
REQ-014 Per beat with err flag set: mem_cs=0, mem_we=0; beat consumed and discarded.
REQ-015 No beat: mem_cs=0, mem_we=0, mem_addr and mem_din 0.
REQ-016 Beat counter starts at 0; current address = latched AWADDR + 4*count; increment per beat; 32-bit add, no 4 KB wrap check beyond REQ-011.
REQ-017 WLAST check: WLAST on beat count==AWLEN is correct; WLAST earlier, or absent at count==AWLEN, sets a protocol-error flag.
REQ-018 Leave DATA after beat with WLAST=1 or beat count==AWLEN, whichever first; remaining memory writes after an early WLAST are not performed.
REQ-019 RESP: WREADY=0; BVALID=1, BID=latched AWID; BRESP=2'b10 (SLVERR) if err or protocol-error flag, else 2'b00 (OKAY).
REQ-020 BID, BRESP, BVALID SHALL stay stable until BVALID&BREADY; then IDLE next cycle, AWREADY=1 that next cycle (no AW accept in RESP cycle).
REQ-021 BREADY already high on BVALID's first cycle: handshake completes in that cycle (RESP lasts one cycle).
REQ-022 WVALID in IDLE or RESP SHALL be ignored, no memory write.
REQ-023 AWLEN=0 single-beat burst: DATA lasts until one beat; WLAST=1 required.

Reset
REQ-024 ARESETn low SHALL immediately force IDLE, counters and flags 0, latched fields 0.
REQ-025 During reset outputs: AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=0, mem_cs=0, mem_we=0, mem_addr=0, mem_din=0.
REQ-026 Reset mid-burst SHALL abandon the transaction without response; first cycle after release AWREADY=1.

Structure
REQ-027 FSM state enum and BRESP constants (OKAY, SLVERR) and burst constant INCR SHALL live in shared package axi_pkg; widths from AXI_define.svh.
REQ-028 Single module; no sub-module required.

Verification
REQ-029 AWADDR=0x100, AWLEN=3, 4 beats data 0xA0..0xA3 WSTRB=4'hF, WLAST on 4th -> mem_addr 0x40..0x43, mem_we=4'hF each beat, BRESP=00, BID=AWID.
REQ-030 AWLEN=0, WSTRB=4'b0011, WDATA=0xDEADBEEF -> single mem write mem_we=4'b0011, BVALID next cycle, BREADY held low 5 cycles -> BVALID/BID/BRESP stable 5 cycles.
REQ-031 AWADDR=0x1_0000 (beyond ADDR_HI) AWLEN=1 -> no mem_cs, 2 beats accepted, BRESP=10.
REQ-032 AWLEN=3, WLAST on 2nd beat -> 2 mem writes, back to RESP, BRESP=10; WVALID afterwards ignored.
REQ-033 AWBURST=2'b10 -> BRESP=10, no memory write.
REQ-034 ARESETn asserted after 2nd beat of AWLEN=3 -> outputs zero immediately, no BVALID, new AW accepted after release.
